alarm_buzzer_ctrl: RTL and testbench
====================================

// Module: alarm_buzzer_ctrl
// PURPOSE
//  Consumes the square-wave tone clkm from the alarm tone oscillator.
//  Gates clkm into a beep pattern (tone ON / silent OFF bursts) when an alarm fires.
//  Sits between the RTC alarm comparator (alarm_match) and the buzzer pin.
//  Ends on user stop, on alarm disable or after a fixed number of bursts.
//  clkm is generated in the clk domain, so no synchroniser is used.
// PARAMETERS
//  ON_CYCLES    25_000_000  clk cycles per tone-ON phase (0.25 s @100 MHz)
//  OFF_CYCLES   25_000_000  clk cycles per silent-OFF phase
//  MAX_BURSTS   120         ON+OFF pairs before automatic timeout
//  CNT_W        25          phase counter width; must hold max(ON,OFF)_CYCLES-1
//  BURST_W      7           burst counter width; must hold MAX_BURSTS-1
//  SNOOZE_CYCLES 36'd30_000_000_000  snooze duration in clk cycles (SNOOZE_EN only)
//  SNOOZE_W     36          snooze counter width
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  clkm           in   1  tone square wave from the oscillator stage
//  alarm_en       in   1  alarm armed (level)
//  alarm_match    in   1  RTC time == alarm time (level; rising edge triggers)
//  stop           in   1  user acknowledge, 1-cycle pulse
//  snooze         in   1  user snooze, 1-cycle pulse (ignored without SNOOZE_EN)
//  buzzer         out  1  gated tone to the buzzer driver
//  alarm_active   out  1  high in ON, OFF and SNOOZE
//  snoozing       out  1  high in SNOOZE (constant 0 without SNOOZE_EN)
//  alarm_timeout  out  1  1-cycle pulse when MAX_BURSTS expire
// BEHAVIOUR
//  Reset values: all outputs 0. State = IDLE. cnt, bursts and match_q = 0.
//  trig = alarm_match & ~match_q & alarm_en; match_q <= alarm_match every cycle.
//  IDLE: on trig go to ON, with cnt=0 and bursts=0. alarm_match still high after stop does not retrigger.
//  ON: cnt++. When cnt==ON_CYCLES-1, go to OFF with cnt=0.
//  OFF: cnt++. When cnt==OFF_CYCLES-1:
//   - if bursts==MAX_BURSTS-1, go to IDLE and pulse alarm_timeout.
//   - otherwise go to ON, with bursts++ and cnt=0.
//  buzzer is registered: buzzer <= (state==ON) & clkm. It has 1-cycle latency vs state and clkm.
//  alarm_active and snoozing are decoded from the registered state (no extra latency).
//  Priority, per cycle: reset > (stop | ~alarm_en) > snooze > counter transitions.
//  stop or ~alarm_en in any non-IDLE state: IDLE next edge, with cnt=0, bursts=0 and no timeout pulse.
//  trig while already non-IDLE is ignored; the pattern is not restarted.
//  Reset mid-burst: state is IDLE next edge and buzzer is 0 next edge.
//  Phase lengths are exact: ON lasts ON_CYCLES cycles, OFF lasts OFF_CYCLES cycles.
//  Latency: trig at edge t gives state ON at t+1 and the first buzzer update at t+2.
// CONFIGURATION
//  SNOOZE_ALARM_EN defined:
//   - snooze in ON/OFF goes to SNOOZE, with snz_cnt=0 and bursts=0.
//   - SNOOZE counts to SNOOZE_CYCLES-1, then goes to ON with cnt=0.
//   - snooze in SNOOZE or IDLE is ignored.
//   - stop and ~alarm_en exit SNOOZE to IDLE.
//  SNOOZE_ALARM_EN undefined: the snooze port stays present but is ignored.
//   - SNOOZE state, snz_cnt and SNOOZE_CYCLES logic are not synthesised.
//   - snoozing is tied to 0.
// TESTING  (ON_CYCLES=4, OFF_CYCLES=3, MAX_BURSTS=2, SNOOZE_CYCLES=10; clkm toggles every clk)
//  1 Reset:
//   - stimulus: reset high 3 cycles with alarm_match=1.
//   - required: buzzer/alarm_active/timeout all 0 and state IDLE throughout.
//  2 Full pattern, alarm_en=1, alarm_match 0->1:
//   - required: alarm_active high for exactly 14 cycles (4+3+4+3).
//   - required: buzzer follows clkm (delayed 1 cycle) only during the two 4-cycle ON windows.
//   - required: alarm_timeout pulses once at the end; no retrigger while match stays 1.
//  3 Stop: pulse stop in the 2nd cycle of ON.
//   - required: IDLE next edge, buzzer 0 the following cycle, no timeout pulse.
//   - stimulus: drop and re-raise alarm_match. Required: a fresh 14-cycle pattern.
//  4 Disable: deassert alarm_en during OFF.
//   - required: IDLE next edge.
//   - stimulus: raise alarm_match while alarm_en=0. Required: no activity.
//  5 Snooze (SNOOZE_ALARM_EN): pulse snooze during ON.
//   - required: snoozing=1 for 10 cycles and buzzer 0, then a full 14-cycle pattern restarts.
//   - build without the macro: snooze has no effect and snoozing stays 0.
//  6 Simultaneous stop+snooze in ON: required IDLE (stop wins); snoozing never asserts.

Source files
------------

// File: rtl/alarm_buzzer_ctrl.sv
// alarm_buzzer_ctrl: gates the tone square wave clkm into ON/OFF beep bursts
// after an RTC alarm match. The alarm ends on stop, on disable, or after
// MAX_BURSTS ON+OFF pairs.
// Optional snooze support is built only when SNOOZE_ALARM_EN is defined.
module alarm_buzzer_ctrl #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000,
    parameter int MAX_BURSTS = 120,
    parameter int CNT_W      = 25,
    parameter int BURST_W    = 7,
    parameter int SNOOZE_W   = 36,
    parameter logic [SNOOZE_W-1:0] SNOOZE_CYCLES = 36'd30_000_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clkm,
    input  logic alarm_en,
    input  logic alarm_match,
    input  logic stop,
    input  logic snooze,
    output logic buzzer,
    output logic alarm_active,
    output logic snoozing,
    output logic alarm_timeout
);

`ifdef SNOOZE_ALARM_EN
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_SNOOZE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;
`endif

    localparam logic [CNT_W-1:0]   ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]   OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURSTS - 1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [BURST_W-1:0]   bursts, bursts_next;
    logic                 match_q;
    logic                 timeout_next;
    logic                 trig;
    logic                 abort;

    assign trig  = alarm_match & ~match_q & alarm_en;
    assign abort = stop | ~alarm_en;

`ifdef SNOOZE_ALARM_EN
    logic [SNOOZE_W-1:0]  snz_cnt, snz_cnt_next;
    localparam logic [SNOOZE_W-1:0] SNZ_LAST = SNOOZE_CYCLES - 1'b1;

    // Snooze duration counter register
    always_ff @(posedge clk) begin
        if (reset) snz_cnt <= '0;
        else       snz_cnt <= snz_cnt_next;
    end

    assign snoozing = (state == S_SNOOZE);
`else
    logic unused_snooze;
    assign unused_snooze = ^{snooze, SNOOZE_CYCLES};
    assign snoozing      = 1'b0;
`endif

    assign alarm_active = (state != S_IDLE);

    // State, phase/burst counters, edge detector and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bursts        <= '0;
            match_q       <= 1'b0;
            buzzer        <= 1'b0;
            alarm_timeout <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bursts        <= bursts_next;
            match_q       <= alarm_match;
            buzzer        <= (state == S_ON) & clkm;
            alarm_timeout <= timeout_next;
        end
    end

    // Next-state logic: abort beats snooze, snooze beats phase expiry
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bursts_next  = bursts;
        timeout_next = 1'b0;
`ifdef SNOOZE_ALARM_EN
        snz_cnt_next = snz_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (trig) begin
                    state_next  = S_ON;
                    cnt_next    = '0;
                    bursts_next = '0;
                end
            end
            S_ON: begin
                if (abort) begin
                    state_next  = S_IDLE;
                    cnt_next    = '0;
                    bursts_next = '0;
`ifdef SNOOZE_ALARM_EN
                end else if (snooze) begin
                    state_next   = S_SNOOZE;
                    snz_cnt_next = '0;
                    bursts_next  = '0;
                    cnt_next     = '0;
`endif
                end else if (cnt == ON_LAST) begin
                    state_next = S_OFF;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_OFF: begin
                if (abort) begin
                    state_next  = S_IDLE;
                    cnt_next    = '0;
                    bursts_next = '0;
`ifdef SNOOZE_ALARM_EN
                end else if (snooze) begin
                    state_next   = S_SNOOZE;
                    snz_cnt_next = '0;
                    bursts_next  = '0;
                    cnt_next     = '0;
`endif
                end else if (cnt == OFF_LAST) begin
                    cnt_next = '0;
                    if (bursts == BURST_LAST) begin
                        state_next   = S_IDLE;
                        bursts_next  = '0;
                        timeout_next = 1'b1;
                    end else begin
                        state_next  = S_ON;
                        bursts_next = bursts + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
`ifdef SNOOZE_ALARM_EN
            S_SNOOZE: begin
                if (abort) begin
                    state_next  = S_IDLE;
                    cnt_next    = '0;
                    bursts_next = '0;
                end else if (snz_cnt == SNZ_LAST) begin
                    state_next = S_ON;
                    cnt_next   = '0;
                end else begin
                    snz_cnt_next = snz_cnt + 1'b1;
                end
            end
`endif
            default: begin
                state_next  = S_IDLE;
                cnt_next    = '0;
                bursts_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// tb_alarm_buzzer_ctrl: directed scenarios for alarm_buzzer_ctrl with
// ON=4, OFF=3, MAX_BURSTS=2, SNOOZE=10 and clkm toggling every clk.
// Cycle index k counts samples after the edge that sees the trigger (k=1 is
// the first ON cycle).
module tb_alarm_buzzer_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clkm = 1'b0;
    logic alarm_en = 1'b1;
    logic alarm_match = 1'b0;
    logic stop = 1'b0;
    logic snooze = 1'b0;
    logic buzzer, alarm_active, snoozing, alarm_timeout;

    int checks = 0;
    int failures = 0;

    alarm_buzzer_ctrl #(
        .ON_CYCLES(4), .OFF_CYCLES(3), .MAX_BURSTS(2),
        .CNT_W(3), .BURST_W(1), .SNOOZE_W(4), .SNOOZE_CYCLES(4'd10)
    ) dut (
        .clk(clk), .reset(reset), .clkm(clkm), .alarm_en(alarm_en),
        .alarm_match(alarm_match), .stop(stop), .snooze(snooze),
        .buzzer(buzzer), .alarm_active(alarm_active), .snoozing(snoozing),
        .alarm_timeout(alarm_timeout)
    );

    always #5 clk = ~clk;

    // Tone toggles on the falling edge so it is stable at every rising edge
    always @(negedge clk) clkm = ~clkm;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop alarm_match for one edge, then raise it; the next edge triggers
    task automatic fire();
        alarm_match = 1'b0;
        step();
        alarm_match = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        alarm_en = 1'b1;
        alarm_match = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({buzzer, alarm_active, alarm_timeout, snoozing} !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL reset_outputs cycle=%0d actual=%b required=0000", i,
                         {buzzer, alarm_active, alarm_timeout, snoozing});
            end
        end
        alarm_match = 1'b0;
        step();
        reset = 1'b0;
        step();
        checks++;
        if (alarm_active !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_idle actual=%b required=0", alarm_active);
        end
    endtask

    task automatic test_full_pattern();
        logic exp_act, exp_buz, exp_to;
        fire();
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_act = (k >= 1 && k <= 14);
            exp_buz = ((k >= 2 && k <= 5) || (k >= 9 && k <= 12)) ? clkm : 1'b0;
            exp_to  = (k == 15);
            checks++;
            if (alarm_active !== exp_act) begin
                failures++;
                $display("[TB] FAIL full_active k=%0d actual=%b required=%b", k, alarm_active, exp_act);
            end
            checks++;
            if (buzzer !== exp_buz) begin
                failures++;
                $display("[TB] FAIL full_buzzer k=%0d actual=%b required=%b", k, buzzer, exp_buz);
            end
            checks++;
            if (alarm_timeout !== exp_to) begin
                failures++;
                $display("[TB] FAIL full_timeout k=%0d actual=%b required=%b", k, alarm_timeout, exp_to);
            end
            // A fresh rising edge of alarm_match mid-pattern must not restart it
            if (k == 3) alarm_match = 1'b0;
            if (k == 5) alarm_match = 1'b1;
        end
    endtask

    task automatic test_stop();
        int act_cnt, to_cnt;
        fire();
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 2) stop = 1'b1;
            if (k == 3) begin
                stop = 1'b0;
                checks++;
                if (alarm_active !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stop_idle k=%0d actual=%b required=0", k, alarm_active);
                end
            end
            if (k == 4) begin
                checks++;
                if (buzzer !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stop_buzzer k=%0d actual=%b required=0", k, buzzer);
                end
            end
            if (k >= 3) begin
                checks++;
                if (alarm_timeout !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stop_no_timeout k=%0d actual=%b required=0", k, alarm_timeout);
                end
            end
        end
        act_cnt = 0;
        to_cnt = 0;
        fire();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (alarm_active === 1'b1) act_cnt++;
            if (alarm_timeout === 1'b1) to_cnt++;
        end
        checks++;
        if (act_cnt != 14) begin
            failures++;
            $display("[TB] FAIL stop_rearm_active_len actual=%0d required=14", act_cnt);
        end
        checks++;
        if (to_cnt != 1) begin
            failures++;
            $display("[TB] FAIL stop_rearm_timeouts actual=%0d required=1", to_cnt);
        end
    endtask

    task automatic test_disable();
        fire();
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) begin
                checks++;
                if (alarm_active !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL disable_in_off k=%0d actual=%b required=1", k, alarm_active);
                end
                alarm_en = 1'b0;
            end
            if (k == 6) begin
                checks++;
                if ({alarm_active, alarm_timeout} !== 2'b00) begin
                    failures++;
                    $display("[TB] FAIL disable_idle k=%0d actual=%b required=00", k,
                             {alarm_active, alarm_timeout});
                end
            end
        end
        fire();
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if ({alarm_active, buzzer, alarm_timeout} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL disabled_no_activity k=%0d actual=%b required=000", k,
                         {alarm_active, buzzer, alarm_timeout});
            end
        end
        alarm_en = 1'b1;
    endtask

    task automatic test_snooze();
        logic exp_act, exp_snz, exp_to;
        fire();
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 3) snooze = 1'b0;
`ifdef SNOOZE_ALARM_EN
            exp_act = (k >= 1 && k <= 26);
            exp_snz = (k >= 3 && k <= 12);
            exp_to  = (k == 27);
            if (k >= 4 && k <= 13) begin
                checks++;
                if (buzzer !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL snooze_buzzer k=%0d actual=%b required=0", k, buzzer);
                end
            end
`else
            exp_act = (k >= 1 && k <= 14);
            exp_snz = 1'b0;
            exp_to  = (k == 15);
`endif
            checks++;
            if (snoozing !== exp_snz) begin
                failures++;
                $display("[TB] FAIL snooze_flag k=%0d actual=%b required=%b", k, snoozing, exp_snz);
            end
            checks++;
            if (alarm_active !== exp_act) begin
                failures++;
                $display("[TB] FAIL snooze_active k=%0d actual=%b required=%b", k, alarm_active, exp_act);
            end
            checks++;
            if (alarm_timeout !== exp_to) begin
                failures++;
                $display("[TB] FAIL snooze_timeout k=%0d actual=%b required=%b", k, alarm_timeout, exp_to);
            end
            if (k == 2) snooze = 1'b1;
        end
    endtask

    task automatic test_stop_and_snooze();
        fire();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 3) begin
                stop = 1'b0;
                snooze = 1'b0;
                checks++;
                if (alarm_active !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stop_wins_idle k=%0d actual=%b required=0", k, alarm_active);
                end
            end
            checks++;
            if (snoozing !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stop_wins_snoozing k=%0d actual=%b required=0", k, snoozing);
            end
            if (k == 2) begin
                stop = 1'b1;
                snooze = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        fire();
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 2) reset = 1'b1;
            if (k == 3) begin
                checks++;
                if ({alarm_active, buzzer} !== 2'b00) begin
                    failures++;
                    $display("[TB] FAIL reset_mid_burst k=%0d actual=%b required=00", k,
                             {alarm_active, buzzer});
                end
            end
        end
        alarm_match = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_full_pattern();
        test_stop();
        test_disable();
        test_snooze();
        test_stop_and_snooze();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
